uart_rx_fifo: RTL and testbench

Receive-side buffer placed directly downstream of the `Uart8` receiver. It captures each completed byte on the rising edge of `rxDone`, stores it in a power-of-two FIFO, and presents it to the consumer over a first-word-fall-through valid/ready interface. It also counts framing errors and flags overflow, so host logic can drain bursts at 9600 baud without losing bytes.

---
 rtl/uart_rx_fifo.sv | 94 +++++++++
 tb/tb_uart_rx_fifo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the Uart8 receiver: rising-edge byte capture, FWFT FIFO,
// overflow flag and saturating error counter. Optional macro RX_FIFO_ERR_TAG_EN stores a per-byte error tag.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          rxDone,
  input  logic          rxErr,
  input  logic [7:0]    rxOut,
  output logic [7:0]    outData,
  output logic          outValid,
  input  logic          outReady,
  output logic          outErr,
  output logic [AW:0]   count,
  output logic          full,
  output logic          overflow,
  input  logic          clrOvf,
  output logic [7:0]    errCount
);

`ifdef RX_FIFO_ERR_TAG_EN
  localparam int MW = 9;
`else
  localparam int MW = 8;
`endif

  logic [MW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          done_q;
  logic          cap;
  logic          err_inc;
  logic          wr_req;
  logic          wr;
  logic          pop;
  logic          ovf_set;
  logic [MW-1:0] wr_data;

  // Handshake: the head byte is presented whenever outValid is high and is
  // consumed on every rising edge where outValid && outReady; outData and
  // outErr hold steady until that edge.
  assign cap     = rxDone && !done_q;
  assign err_inc = cap && rxErr;

`ifdef RX_FIFO_ERR_TAG_EN
  assign wr_req  = cap;
  assign wr_data = {rxErr, rxOut};
  assign outErr  = mem[rd_ptr][8];
`else
  assign wr_req  = cap && !rxErr;
  assign wr_data = rxOut;
  assign outErr  = 1'b0;
`endif

  assign outValid = (count != '0);
  // count never exceeds DEPTH, so its top bit alone marks the full state
  assign full     = count[AW];
  assign pop      = outValid && outReady;
  assign wr       = wr_req && (!full || pop);
  assign ovf_set  = wr_req && full && !pop;
  assign outData  = mem[rd_ptr][7:0];

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      // rxDone already high at release counts as seen, so it cannot capture
      done_q   <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      errCount <= 8'd0;
    end else begin
      done_q <= rxDone;
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set)     overflow <= 1'b1;
      else if (clrOvf) overflow <= 1'b0;
      if (clrOvf)                            errCount <= err_inc ? 8'd1 : 8'd0;
      else if (err_inc && errCount != 8'hFF) errCount <= errCount + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: randomized and directed UART byte traffic
// checked against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AW = 4;
`ifdef RX_FIFO_ERR_TAG_EN
  localparam bit TAG = 1'b1;
`else
  localparam bit TAG = 1'b0;
`endif

  logic        clk;
  logic        rstN;
  logic        rxDone;
  logic        rxErr;
  logic [7:0]  rxOut;
  logic [7:0]  outData;
  logic        outValid;
  logic        outReady;
  logic        outErr;
  logic [AW:0] count;
  logic        full;
  logic        overflow;
  logic        clrOvf;
  logic [7:0]  errCount;

  int checks = 0;
  int failures = 0;

  logic [8:0] exp_q[$];
  bit         m_done;
  bit         m_ovf;
  int         m_err;
  bit         rnd_done;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstN(rstN), .rxDone(rxDone), .rxErr(rxErr), .rxOut(rxOut),
    .outData(outData), .outValid(outValid), .outReady(outReady), .outErr(outErr),
    .count(count), .full(full), .overflow(overflow), .clrOvf(clrOvf),
    .errCount(errCount)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic send(input logic [7:0] d, input bit e, input int hold, input int idle);
    @(posedge clk); #1;
    rxDone = 1'b1; rxOut = d; rxErr = e;
    repeat (hold) @(posedge clk);
    #1;
    rxDone = 1'b0; rxOut = 8'($urandom); rxErr = 1'($urandom);
    repeat (idle) @(posedge clk);
  endtask

  task automatic drain();
    @(posedge clk); #1 outReady = 1'b1;
    repeat (DEPTH + 2) @(posedge clk);
    #1 outReady = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clrOvf = 1'b1;
    @(posedge clk); #1 clrOvf = 1'b0;
  endtask

  // scoreboard monitor: compares at the falling edge, then predicts the next rising edge
  always @(negedge clk) begin : mon
    bit cap, pop, err_inc, ovf_set;
    if (!rstN) begin
      exp_q.delete();
      m_done = 1'b1;
      m_ovf  = 1'b0;
      m_err  = 0;
    end else begin
      check("out_valid", 32'(outValid), 32'(exp_q.size() != 0));
      check("count", 32'(count), 32'(exp_q.size()));
      check("full", 32'(full), 32'(exp_q.size() == DEPTH));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("err_count", 32'(errCount), 32'(m_err));
      if (exp_q.size() != 0) begin
        check("out_data", 32'(outData), 32'(exp_q[0][7:0]));
        check("out_err", 32'(outErr), 32'(exp_q[0][8]));
      end
      cap     = rxDone && !m_done;
      m_done  = rxDone;
      err_inc = cap && rxErr;
      pop     = outReady && (exp_q.size() != 0);
      ovf_set = 1'b0;
      if (pop) void'(exp_q.pop_front());
      if (cap && (TAG || !rxErr)) begin
        if (exp_q.size() < DEPTH) exp_q.push_back({rxErr & TAG, rxOut});
        else ovf_set = 1'b1;
      end
      if (ovf_set)     m_ovf = 1'b1;
      else if (clrOvf) m_ovf = 1'b0;
      if (clrOvf)                      m_err = err_inc ? 1 : 0;
      else if (err_inc && m_err < 255) m_err = m_err + 1;
    end
  end

  initial begin
    rstN = 1'b0; rxDone = 1'b0; rxErr = 1'b0; rxOut = 8'h00;
    outReady = 1'b0; clrOvf = 1'b0; rnd_done = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", 32'(outValid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_err_count", 32'(errCount), 32'd0);
    check("rst_out_err", 32'(outErr), 32'd0);
    @(posedge clk); #1 rstN = 1'b1;

    // basic byte, then pop
    send(8'h56, 1'b0, 1, 3);
    drain();

    // held level gives a single capture
    send(8'hA5, 1'b0, 100, 3);
    drain();

    // fill past full, drain, clear overflow
    for (int i = 0; i <= DEPTH; i++) send(8'(i), 1'b0, 1, 1);
    repeat (2) @(posedge clk);
    drain();
    pulse_clr();

    // full with simultaneous capture and pop
    for (int i = 0; i < DEPTH; i++) send(8'(8'hC0 + i), 1'b0, 1, 0);
    @(posedge clk); #1;
    rxDone = 1'b1; rxOut = 8'hEE; rxErr = 1'b0; outReady = 1'b1;
    @(posedge clk); #1;
    rxDone = 1'b0; outReady = 1'b0;
    repeat (2) @(posedge clk);
    drain();

    // error byte
    send(8'h33, 1'b1, 1, 3);
    drain();

    // randomized traffic with a random consumer and occasional clears
    fork
      begin
        for (int i = 0; i < 60; i++)
          send(8'($urandom), ($urandom_range(0, 7) == 0), $urandom_range(1, 4), $urandom_range(0, 3));
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          outReady = ($urandom_range(0, 3) == 0);
          clrOvf   = ($urandom_range(0, 31) == 0);
        end
        outReady = 1'b0;
        clrOvf   = 1'b0;
      end
    join
    drain();

    // asynchronous reset mid-burst, released with rxDone high
    for (int i = 0; i < 5; i++) send(8'(8'h10 + i), 1'b0, 1, 1);
    @(posedge clk); #2;
    rstN = 1'b0; rxDone = 1'b1; rxOut = 8'h99; rxErr = 1'b0;
    #1;
    check("async_out_valid", 32'(outValid), 32'd0);
    check("async_count", 32'(count), 32'd0);
    check("async_overflow", 32'(overflow), 32'd0);
    check("async_err_count", 32'(errCount), 32'd0);
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    repeat (3) @(posedge clk);
    #1 rxDone = 1'b0;
    send(8'h7F, 1'b0, 1, 2);
    drain();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
